// File: rtl/conv_pass_sequencer.sv
// Layer-level pass scheduler: walks (output channel, input channel) pairs, sequencing the
// weight load, one window-counter pass, the MAC drain and the per-output-channel write-back.
module conv_pass_sequencer #(
  parameter int CH_W      = 8,
  parameter int SIZE_W    = 8,
  parameter int DRAIN_CYC = 2,
  parameter int TIMEOUT   = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [SIZE_W-1:0] cfg_size,
  input  logic [CH_W-1:0]   cfg_in_ch,
  input  logic [CH_W-1:0]   cfg_out_ch,
  output logic [SIZE_W-1:0] cnt_size,
  output logic              cnt_enable,
  input  logic              cnt_end,
  output logic              w_load_req,
  input  logic              w_load_ack,
  output logic              acc_clear,
  output logic              ofmap_wr,
  output logic [CH_W-1:0]   in_ch_idx,
  output logic [CH_W-1:0]   out_ch_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_RUN,
    S_GAP,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_t             state_reg;
  logic [CH_W-1:0]    in_ch_reg;
  logic [CH_W-1:0]    out_ch_reg;
  logic [DRAIN_W-1:0] drain_cnt_reg;
  logic [15:0]        wd_cnt_reg;
  logic               cfg_bad;

  assign cfg_bad = (cfg_in_ch == '0) || (cfg_out_ch == '0) || (cfg_size < SIZE_W'(2));

  // All outputs are registered; pulse outputs are set on the edge entering the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      in_ch_reg     <= '0;
      out_ch_reg    <= '0;
      drain_cnt_reg <= '0;
      wd_cnt_reg    <= '0;
      cnt_size      <= '0;
      cnt_enable    <= 1'b0;
      w_load_req    <= 1'b0;
      acc_clear     <= 1'b0;
      ofmap_wr      <= 1'b0;
      in_ch_idx     <= '0;
      out_ch_idx    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      acc_clear <= 1'b0;
      ofmap_wr  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      if (abort) begin
        state_reg     <= S_IDLE;
        drain_cnt_reg <= '0;
        wd_cnt_reg    <= '0;
        cnt_size      <= '0;
        cnt_enable    <= 1'b0;
        w_load_req    <= 1'b0;
        in_ch_idx     <= '0;
        out_ch_idx    <= '0;
        busy          <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (start) begin
              cnt_size   <= cfg_size;
              in_ch_reg  <= cfg_in_ch;
              out_ch_reg <= cfg_out_ch;
              if (cfg_bad) begin
                err <= 1'b1;
              end else begin
                in_ch_idx  <= '0;
                out_ch_idx <= '0;
                w_load_req <= 1'b1;
                acc_clear  <= 1'b1;
                busy       <= 1'b1;
                state_reg  <= S_WLOAD;
              end
            end
          end
          S_WLOAD: begin
            if (w_load_ack) begin
              w_load_req <= 1'b0;
              cnt_enable <= 1'b1;
              wd_cnt_reg <= '0;
              state_reg  <= S_RUN;
            end
          end
          S_RUN: begin
            // The counter keeps asserting end while enabled, so leave on the first one seen.
            if (cnt_end) begin
              cnt_enable <= 1'b0;
              state_reg  <= S_GAP;
            end else if (wd_cnt_reg == 16'(TIMEOUT - 1)) begin
              cnt_enable <= 1'b0;
              err        <= 1'b1;
              busy       <= 1'b0;
              in_ch_idx  <= '0;
              out_ch_idx <= '0;
              state_reg  <= S_IDLE;
            end else begin
              wd_cnt_reg <= wd_cnt_reg + 16'd1;
            end
          end
          S_GAP: begin
            if (in_ch_idx < in_ch_reg - CH_W'(1)) begin
              in_ch_idx  <= in_ch_idx + CH_W'(1);
              w_load_req <= 1'b1;
              state_reg  <= S_WLOAD;
            end else begin
              drain_cnt_reg <= '0;
              state_reg     <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (drain_cnt_reg == DRAIN_W'(DRAIN_CYC - 1)) begin
              ofmap_wr  <= 1'b1;
              state_reg <= S_WRITE;
            end else begin
              drain_cnt_reg <= drain_cnt_reg + DRAIN_W'(1);
            end
          end
          S_WRITE: begin
            if (out_ch_idx < out_ch_reg - CH_W'(1)) begin
              out_ch_idx <= out_ch_idx + CH_W'(1);
              in_ch_idx  <= '0;
              w_load_req <= 1'b1;
              acc_clear  <= 1'b1;
              state_reg  <= S_WLOAD;
            end else begin
              done      <= 1'b1;
              state_reg <= S_DONE;
            end
          end
          S_DONE: begin
            busy      <= 1'b0;
            state_reg <= S_IDLE;
          end
          default: begin
            state_reg <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
